// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word block fill and per-set round-robin replacement.
// Optional macro ICACHE_FLUSH_EN adds an iflush port that invalidates every line and aborts any fill.
module icache_assoc #(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
`ifdef ICACHE_FLUSH_EN
   input  logic        iflush,
`endif
   input  logic [31:0] iload
);

   localparam int WB      = $clog2(WORDS);
   localparam int IDX_W   = $clog2(SETS);
   localparam int WOFF_W  = (WORDS > 1) ? WB : 1;
   localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_LSB = 2 + WB + IDX_W;
   localparam int TAG_W   = 32 - TAG_LSB;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                r_state;
   logic [WOFF_W-1:0]     r_cnt;
   logic                  r_iren;
   logic [31:0]           r_iaddr;
   logic [WAY_W-1:0]      r_victim;
   logic [IDX_W-1:0]      r_fill_idx;
   logic [TAG_W-1:0]      r_fill_tag;
   logic [WAYS-1:0]       r_valid [SETS];
   logic [WAY_W-1:0]      r_ptr   [SETS];
   logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
   logic [31:0]           r_data  [SETS][WAYS][WORDS];
   logic [31:0]           r_buf   [WORDS];

   logic                  w_flush;
   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [WOFF_W-1:0]     w_woff;
   logic [31:0]           w_base;
   logic                  w_hit_any;
   logic [WAY_W-1:0]      w_hit_way;
   logic [WAY_W-1:0]      w_victim;
   logic [WAY_W-1:0]      w_ptr_next;
   logic                  w_hit;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_install;

`ifdef ICACHE_FLUSH_EN
   assign w_flush = iflush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_idx  = IDX_W'(imemaddr >> (2 + WB));
   assign w_tag  = imemaddr[31:TAG_LSB];
   assign w_woff = WOFF_W'((imemaddr >> 2) & 32'(WORDS - 1));
   assign w_base = imemaddr & ~(32'(WORDS * 4 - 1));

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_hit_any = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit_any = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   // Scanning downward leaves the lowest-numbered invalid way; the pointer is used only when the set is full.
   always_comb begin
      w_victim = r_ptr[w_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
      end
   end

   assign w_ptr_next = (r_ptr[r_fill_idx] == WAY_W'(WAYS - 1)) ? '0 : r_ptr[r_fill_idx] + 1'b1;

   assign w_hit     = (r_state == IDLE) && imemREN && w_hit_any && !w_flush;
   assign w_accept  = (r_state == FILL) && !iwait;
   assign w_last    = (r_cnt == WOFF_W'(WORDS - 1));
   assign w_install = w_accept && w_last && !w_flush;

   assign ihit     = w_hit;
   assign imemload = w_hit ? r_data[w_idx][w_hit_way][w_woff] : 32'd0;
   assign iREN     = r_iren && !w_flush;
   assign iaddr    = w_flush ? 32'd0 : r_iaddr;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_iren     <= 1'b0;
         r_iaddr    <= '0;
         r_victim   <= '0;
         r_fill_idx <= '0;
         r_fill_tag <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_ptr[s]   <= '0;
         end
      end else if (w_flush) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_iren  <= 1'b0;
         r_iaddr <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_ptr[s]   <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (imemREN && !w_hit_any) begin
                  r_state    <= FILL;
                  r_fill_idx <= w_idx;
                  r_fill_tag <= w_tag;
                  r_victim   <= w_victim;
                  r_cnt      <= '0;
                  r_iren     <= 1'b1;
                  r_iaddr    <= w_base;
               end
            end
            FILL: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_valid[r_fill_idx][r_victim] <= 1'b1;
                     r_ptr[r_fill_idx]             <= w_ptr_next;
                     r_state                       <= IDLE;
                     r_cnt                         <= '0;
                     r_iren                        <= 1'b0;
                     r_iaddr                       <= '0;
                  end else begin
                     r_cnt   <= r_cnt + 1'b1;
                     r_iaddr <= r_iaddr + 32'd4;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // NOTE: tag, data and fill-buffer storage have no reset; the valid bits alone qualify their contents.
   always_ff @(posedge CLK) begin
      if (w_accept) r_buf[r_cnt] <= iload;
      if (w_install) begin
         r_tag[r_fill_idx][r_victim] <= r_fill_tag;
         for (int k = 0; k < WORDS; k++) begin
            r_data[r_fill_idx][r_victim][k] <= (k == WORDS - 1) ? iload : r_buf[k];
         end
      end
   end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus random fetches against a set/way model.
// Flush scenarios run only when ICACHE_FLUSH_EN is defined.
module tb_icache_assoc;

   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_FLUSH_EN
   logic        iflush;
`endif

   int total = 0;
   int bad   = 0;

   icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
`ifdef ICACHE_FLUSH_EN
      .iflush   (iflush),
`endif
      .iload    (iload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always_comb iload = 32'hA000_0000 | iaddr;

   // Reference model: which tags live in which set/way, and each set's round-robin pointer.
   bit          m_valid [SETS][WAYS];
   logic [31:0] m_tag   [SETS][WAYS];
   int          m_ptr   [SETS];

   function automatic int m_set(input logic [31:0] a);
      return int'((a / (4 * WORDS)) % SETS);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] a);
      return a / (4 * WORDS * SETS);
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 | (a & ~32'd3);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[m_set(a)][w] && m_tag[m_set(a)][w] == m_tagof(a)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int s = 0; s < SETS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endtask

   task automatic m_install(input logic [31:0] a);
      int s, v;
      s = m_set(a);
      v = -1;
      for (int w = 0; w < WAYS; w++)
         if (v < 0 && !m_valid[s][w]) v = w;
      if (v < 0) v = m_ptr[s];
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = m_tagof(a);
      m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      imemREN  = 1'b0;
      imemaddr = 32'd0;
      iwait    = 1'b0;
`ifdef ICACHE_FLUSH_EN
      iflush   = 1'b0;
`endif
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
      m_clear();
   endtask

   // mode 0: no waits, 1: random waits, 2: three wait cycles before each word.
   task automatic fetch(input logic [31:0] a, input int mode, output logic got_hit, output int lat);
      logic [31:0] base;
      bit          exp_hit;
      int          k, waits, cyc;
      exp_hit  = m_hit(a);
      base     = a & ~32'(WORDS * 4 - 1);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b0;
      lat      = 0;
      @(negedge CLK);
      got_hit = ihit;
      total++;
      if (ihit !== exp_hit) begin
         bad++;
         $display("FAIL lookup addr=%h ihit=%b expected=%b", a, ihit, exp_hit);
      end
      total++;
      if (iREN !== 1'b0) begin
         bad++;
         $display("FAIL iren_idle addr=%h iREN=%b expected=0", a, iREN);
      end
      if (exp_hit) begin
         total++;
         if (imemload !== mem_word(a)) begin
            bad++;
            $display("FAIL hit_data addr=%h imemload=%h expected=%h", a, imemload, mem_word(a));
         end
      end
      tick();
      if (!exp_hit) begin
         k = 0; waits = 0; cyc = 1;
         while (k < WORDS && cyc < 200) begin
            case (mode)
               1:       iwait = ($urandom_range(0, 2) == 0);
               2:       iwait = (waits < 3);
               default: iwait = 1'b0;
            endcase
            @(negedge CLK);
            total++;
            if (iREN !== 1'b1 || iaddr !== base + 32'(4 * k) || ihit !== 1'b0) begin
               bad++;
               $display("FAIL fill_req cyc=%0d iREN=%b iaddr=%h ihit=%b expected iREN=1 iaddr=%h ihit=0",
                        cyc, iREN, iaddr, ihit, base + 32'(4 * k));
            end
            tick();
            if (!iwait) begin
               k++;
               waits = 0;
            end else begin
               waits++;
            end
            cyc++;
         end
         total++;
         if (k < WORDS) begin
            bad++;
            $display("FAIL fill_timeout words=%0d expected=%0d", k, WORDS);
         end
         iwait = 1'b0;
         m_install(a);
         lat = cyc;
         @(negedge CLK);
         total++;
         if (ihit !== 1'b1 || imemload !== mem_word(a)) begin
            bad++;
            $display("FAIL post_fill addr=%h ihit=%b imemload=%h expected ihit=1 imemload=%h",
                     a, ihit, imemload, mem_word(a));
         end
         tick();
      end
      imemREN = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      total++;
      if ({ihit, iREN} !== 2'b00 || imemload !== 32'd0 || iaddr !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs ihit=%b iREN=%b imemload=%h iaddr=%h expected all 0",
                  ihit, iREN, imemload, iaddr);
      end
      tick();
   endtask

   task automatic test_cold_miss();
      do_reset();
      imemREN = 1'b1; imemaddr = 32'h40;
      @(negedge CLK);
      total++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin
         bad++;
         $display("FAIL cold_c0 ihit=%b iREN=%b expected 0 0", ihit, iREN);
      end
      tick();
      @(negedge CLK);
      total++;
      if (iREN !== 1'b1 || iaddr !== 32'h40) begin
         bad++;
         $display("FAIL cold_c1 iREN=%b iaddr=%h expected 1 00000040", iREN, iaddr);
      end
      tick();
      @(negedge CLK);
      total++;
      if (iREN !== 1'b1 || iaddr !== 32'h44) begin
         bad++;
         $display("FAIL cold_c2 iREN=%b iaddr=%h expected 1 00000044", iREN, iaddr);
      end
      tick();
      @(negedge CLK);
      total++;
      if (ihit !== 1'b1 || imemload !== 32'hA000_0040 || iREN !== 1'b0) begin
         bad++;
         $display("FAIL cold_c3 ihit=%b imemload=%h iREN=%b expected 1 a0000040 0", ihit, imemload, iREN);
      end
      tick();
      imemaddr = 32'h44;
      @(negedge CLK);
      total++;
      if (ihit !== 1'b1 || imemload !== 32'hA000_0044 || iREN !== 1'b0) begin
         bad++;
         $display("FAIL same_block ihit=%b imemload=%h iREN=%b expected 1 a0000044 0", ihit, imemload, iREN);
      end
      tick();
      imemREN = 1'b0;
      m_install(32'h40);
   endtask

   task automatic test_replacement();
      logic h;
      int   lat;
      logic [31:0] seq  [7] = '{32'h040, 32'h240, 32'h440, 32'h240, 32'h040, 32'h440, 32'h240};
      logic        want [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         fetch(seq[i], 0, h, lat);
         total++;
         if (h !== want[i]) begin
            bad++;
            $display("FAIL replace step=%0d addr=%h hit=%b expected=%b", i, seq[i], h, want[i]);
         end
      end
   endtask

   task automatic test_wait_states();
      logic h;
      int   lat;
      do_reset();
      fetch(32'h40, 2, h, lat);
      total++;
      if (lat !== 9) begin
         bad++;
         $display("FAIL wait_latency ihit_cycle=%0d expected=9", lat);
      end
   endtask

   task automatic test_reset_mid_fill();
      logic h;
      int   lat;
      do_reset();
      imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
      tick();
      tick();
      nRST = 1'b0;
      #1;
      total++;
      if ({ihit, iREN} !== 2'b00 || imemload !== 32'd0 || iaddr !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_fill ihit=%b iREN=%b imemload=%h iaddr=%h expected all 0",
                  ihit, iREN, imemload, iaddr);
      end
      tick();
      nRST = 1'b1;
      m_clear();
      fetch(32'h40, 0, h, lat);
      total++;
      if (h !== 1'b0 || lat !== WORDS + 1) begin
         bad++;
         $display("FAIL refetch_after_reset hit=%b lat=%0d expected hit=0 lat=%0d", h, lat, WORDS + 1);
      end
   endtask

   task automatic test_addr_change();
      logic h;
      int   lat;
      do_reset();
      imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
      tick();
      imemaddr = 32'h80;
      @(negedge CLK);
      total++;
      if (iREN !== 1'b1 || iaddr !== 32'h40) begin
         bad++;
         $display("FAIL chg_w0 iREN=%b iaddr=%h expected 1 00000040", iREN, iaddr);
      end
      tick();
      @(negedge CLK);
      total++;
      if (iREN !== 1'b1 || iaddr !== 32'h44) begin
         bad++;
         $display("FAIL chg_w1 iREN=%b iaddr=%h expected 1 00000044", iREN, iaddr);
      end
      tick();
      m_install(32'h40);
      fetch(32'h80, 0, h, lat);
      total++;
      if (h !== 1'b0) begin
         bad++;
         $display("FAIL chg_new_miss hit=%b expected=0", h);
      end
      fetch(32'h40, 0, h, lat);
      total++;
      if (h !== 1'b1) begin
         bad++;
         $display("FAIL chg_old_hit hit=%b expected=1", h);
      end
   endtask

`ifdef ICACHE_FLUSH_EN
   task automatic test_flush();
      logic h;
      int   lat;
      do_reset();
      fetch(32'h40, 0, h, lat);
      iflush = 1'b1;
      tick();
      iflush = 1'b0;
      m_clear();
      fetch(32'h40, 0, h, lat);
      total++;
      if (h !== 1'b0) begin
         bad++;
         $display("FAIL post_flush_hit hit=%b expected=0", h);
      end
      imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b0;
      tick();
      iflush = 1'b1;
      @(negedge CLK);
      total++;
      if (iREN !== 1'b0 || ihit !== 1'b0) begin
         bad++;
         $display("FAIL flush_cycle iREN=%b ihit=%b expected 0 0", iREN, ihit);
      end
      tick();
      iflush = 1'b0; imemREN = 1'b0;
      @(negedge CLK);
      total++;
      if (iREN !== 1'b0) begin
         bad++;
         $display("FAIL flush_abort iREN=%b expected=0", iREN);
      end
      tick();
      m_clear();
      fetch(32'h80, 0, h, lat);
      total++;
      if (h !== 1'b0) begin
         bad++;
         $display("FAIL flush_no_install hit=%b expected=0", h);
      end
   endtask
`endif

   task automatic test_random();
      logic        h;
      int          lat;
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'd3) : (32'($urandom_range(0, 511)) << 2);
         if ($urandom_range(0, 5) == 0) begin
            imemREN = 1'b0; imemaddr = a;
            @(negedge CLK);
            total++;
            if ({ihit, iREN} !== 2'b00 || imemload !== 32'd0 || iaddr !== 32'd0) begin
               bad++;
               $display("FAIL idle_outputs ihit=%b iREN=%b imemload=%h iaddr=%h expected all 0",
                        ihit, iREN, imemload, iaddr);
            end
            tick();
         end else begin
            fetch(a, 1, h, lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_replacement();
      test_wait_states();
      test_reset_mid_fill();
      test_addr_change();
`ifdef ICACHE_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache. It is the next generation of the direct-mapped, one-word-per-line icache and sits between the datapath fetch port and the memory-controller instruction port. It supports configurable sets, ways and words per block, a multi-cycle block-fill state machine, and round-robin replacement. Hits are returned combinationally in the same cycle; misses stall the datapath until the whole block has been fetched and installed.

## Interface
Parameters:
- SETS, 8, number of sets; power of two, at least 2
- WAYS, 2, ways per set; power of two, at least 1 (1 gives direct-mapped)
- WORDS, 2, 32-bit words per block; power of two, at least 1

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  datapath fetch byte address
- ihit  out  1  hit/ready to datapath
- imemload  out  32  fetched instruction; 0 when ihit=0
- iREN  out  1  memory read request
- iaddr  out  32  memory word address; 0 when iREN=0
- iwait  in  1  memory busy; a word is accepted in any cycle with iREN=1 and iwait=0
- iload  in  32  memory read data, valid when iwait=0
- iflush  in  1  present only with ICACHE_FLUSH_EN; invalidate all lines

## Operation
- Address split: bytoff=[1:0]; woff=next log2(WORDS) bits; idx=next log2(SETS) bits; tag=all remaining upper bits. With defaults: woff=[2], idx=[5:3], tag=[31:6].
- Line state: valid bit, tag, and WORDS data words per way. Each set also holds a round-robin pointer of log2(WAYS) bits.
- Hit: imemREN=1, and some way in set idx is valid with a matching tag. Then ihit=1 and imemload is that way's word at woff. The lookup is combinational and is performed only in IDLE.
- FSM has two states, IDLE and FILL.
- IDLE:
  - On a miss with imemREN=1, latch the block base (imemaddr with woff and bytoff cleared), latch the victim way, set word counter cnt=0, and go to FILL.
  - With imemREN=0, stay in IDLE, assert no outputs, and leave state unchanged.
- FILL:
  - Drive iREN=1 and iaddr=base+4*cnt. ihit=0.
  - On each accepted word (iwait=0), store iload in fill-buffer slot cnt and increment cnt.
  - When the last word (cnt=WORDS-1) is accepted, write the fill buffer, tag and valid=1 into the victim way, and return to IDLE.
- Victim selection: the lowest-numbered invalid way in the set. If all ways are valid, the way given by the set's pointer.
- The set's pointer advances by 1 modulo WAYS on every install. Hits do not move it.
- The block fill is never cancelled because imemaddr changes or imemREN drops. The line is installed, and the new address is then looked up from IDLE.
- If a refetch installs the same tag twice (which cannot happen from IDLE), the line is overwritten with no other effect.

## Timing
- Reset values: all valid bits 0, all pointers 0, state IDLE, cnt 0. ihit=0, imemload=0, iREN=0, iaddr=0.
- nRST asserted during FILL aborts the fill immediately. No partial line is installed.
- Hit latency is 0 cycles (combinational).
- Miss timeline, with the miss seen in cycle 0:
  - FILL occupies cycles 1 onward.
  - With iwait=0 throughout, words are requested in cycles 1..WORDS.
  - ihit=1 in cycle WORDS+1.
- Each cycle with iwait=1 adds one cycle. iaddr is held stable while iwait=1.
- iREN is never asserted in IDLE. There is no request in the cycle the miss is detected.

## Configuration
- ICACHE_FLUSH_EN defined: adds the iflush port.
  - In the cycle iflush=1, ihit and iREN are forced to 0.
  - On that edge, all valid bits and pointers are cleared and the FSM goes to IDLE, aborting any fill in progress with no install.
  - iflush has priority over a simultaneous last-word accept.
- ICACHE_FLUSH_EN undefined: there is no iflush port, and lines are invalidated only by nRST.

## Test plan
Defaults SETS=8, WAYS=2, WORDS=2; memory returns iload = 0xA0000000 | iaddr unless stated.
- Cold miss, then same-block hit:
  - Stimulus: reset, then imemREN=1 with imemaddr=0x40; iwait=0.
  - Required: cycle 0 ihit=0, iREN=0; cycle 1 iaddr=0x40; cycle 2 iaddr=0x44; cycle 3 ihit=1, imemload=0xA0000040.
  - Then imemaddr=0x44 gives ihit=1, imemload=0xA0000044, iREN=0.
- Replacement:
  - Stimulus: fill 0x040, 0x240, then 0x440 (all set 0).
  - Required: 0x440 evicts way 0 (0x040). 0x240 still hits; 0x040 misses and then evicts way 1 (0x240).
- Wait states:
  - Stimulus: iwait=1 for 3 cycles before each word.
  - Required: iaddr holds 0x40 for 4 cycles, then 0x44 for 4 cycles; ihit rises in cycle 9.
- Reset mid-fill:
  - Stimulus: pulse nRST low after word 0 of 0x40 is accepted.
  - Required: all outputs 0 immediately; a re-request of 0x40 misses and refetches both words.
- Address change mid-fill:
  - Stimulus: switch imemaddr to 0x80 during the 0x40 fill.
  - Required: the fill completes (iaddr 0x40, then 0x44); 0x80 then misses. Afterwards 0x40 hits.
- Flush (ICACHE_FLUSH_EN defined):
  - Stimulus: after filling 0x40, pulse iflush, then fetch 0x40. Separately, assert iflush in cycle 1 of a fill.
  - Required: the post-flush fetch of 0x40 misses. Flushing in cycle 1 of a fill drops iREN in cycle 2 and installs nothing.
